// File: rtl/digital_fll_ctrl.sv
// Frequency-locked-loop controller for a ring-oscillator clock source.
// Counts DCO cycles per reference (osc) period and steps a thermometer
// trim code until the measured count matches the programmed divide ratio.
module digital_fll_ctrl #(
  parameter int unsigned TRIM_WIDTH = 26,
  parameter int unsigned DIV_WIDTH  = 5,
  parameter int unsigned CNT_WIDTH  = 7,
  parameter int unsigned TRIM_INIT  = 13,
  parameter int unsigned TOL        = 0,
  parameter int unsigned COARSE_THR = 4,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  dco,
  input  logic                  osc,
  input  logic [DIV_WIDTH-1:0]  div,
  input  logic [TRIM_WIDTH-1:0] ext_trim,
  output logic [TRIM_WIDTH-1:0] trim,
  output logic                  locked,
  output logic [CNT_WIDTH-1:0]  meas,
  output logic                  meas_valid
);

  localparam int unsigned TVW = $clog2(TRIM_WIDTH + 1);
  localparam int unsigned LKW = $clog2(LOCK_COUNT + 1);
  localparam int unsigned EW  = CNT_WIDTH + 1;

  typedef enum logic [1:0] {StIdle, StArm, StTrack, StLocked} state_e;

  state_e               state_q;
  logic                 osc_meta_q, osc_sync_q, osc_hist_q;
  logic                 rise;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_inc;
  logic [TVW-1:0]       tval_q, tval_inc, tval_dec;
  logic [LKW-1:0]       lk_q, lk_inc;
  logic                 lock_hit;
  logic [EW-1:0]        err, err_abs;
  logic                 in_band, too_fast;
  logic [TVW:0]         tval_ext, step_ext, tval_sum;

  function automatic logic [TRIM_WIDTH-1:0] thermo(input logic [TVW-1:0] lvl);
    logic [TRIM_WIDTH-1:0] t;
    for (int i = 0; i < int'(TRIM_WIDTH); i++) begin
      t[i] = (i < int'(lvl));
    end
    return t;
  endfunction

  // Bring osc into the clock domain and keep one history bit for edge detection.
  always_ff @(posedge clock) begin
    if (reset) begin
      osc_meta_q <= 1'b0;
      osc_sync_q <= 1'b0;
      osc_hist_q <= 1'b0;
    end else begin
      osc_meta_q <= osc;
      osc_sync_q <= osc_meta_q;
      osc_hist_q <= osc_sync_q;
    end
  end

  assign rise = osc_sync_q & ~osc_hist_q;

  // Error, step size and clamped trim candidates for the current count.
  always_comb begin
    cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    // Zero-extended subtraction; bit EW-1 is the sign since cnt and div never overflow EW bits.
    err      = {1'b0, cnt_q} - {{(EW - DIV_WIDTH){1'b0}}, div};
    err_abs  = err[EW-1] ? (~err + 1'b1) : err;
    in_band  = (err_abs <= EW'(TOL));
    too_fast = !err[EW-1] && !in_band;
    tval_ext = {1'b0, tval_q};
    step_ext = (err_abs >= EW'(COARSE_THR)) ? (TVW+1)'(2) : (TVW+1)'(1);
    tval_sum = tval_ext + step_ext;
    tval_inc = (tval_sum > (TVW+1)'(TRIM_WIDTH)) ? TVW'(TRIM_WIDTH) : tval_sum[TVW-1:0];
    tval_dec = (tval_ext < step_ext) ? '0 : TVW'(tval_ext - step_ext);
    lk_inc   = (lk_q >= LKW'(LOCK_COUNT)) ? lk_q : lk_q + 1'b1;
    lock_hit = (lk_inc >= LKW'(LOCK_COUNT));
  end

  // Loop FSM with registered trim, lock and measurement outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      tval_q     <= TVW'(TRIM_INIT);
      cnt_q      <= '0;
      lk_q       <= '0;
      trim       <= thermo(TVW'(TRIM_INIT));
      locked     <= 1'b0;
      meas       <= '0;
      meas_valid <= 1'b0;
    end else if (!enable) begin
      state_q    <= StIdle;
      tval_q     <= TVW'(TRIM_INIT);
      cnt_q      <= '0;
      lk_q       <= '0;
      trim       <= thermo(tval_q);
      locked     <= 1'b0;
      meas_valid <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      cnt_q      <= rise ? CNT_WIDTH'(1) : cnt_inc;
      trim       <= dco ? ext_trim : thermo(tval_q);
      unique case (state_q)
        StIdle: begin
          cnt_q   <= '0;
          state_q <= StArm;
        end
        // First rise only aligns the counter to the reference.
        StArm: begin
          if (rise) state_q <= StTrack;
        end
        StTrack, StLocked: begin
          if (rise) begin
            meas       <= cnt_q;
            meas_valid <= 1'b1;
            if (dco || (div == '0)) begin
              lk_q    <= '0;
              locked  <= 1'b0;
              state_q <= StTrack;
            end else if (in_band) begin
              lk_q <= lk_inc;
              if (lock_hit) begin
                locked  <= 1'b1;
                state_q <= StLocked;
              end
            end else begin
              lk_q    <= '0;
              locked  <= 1'b0;
              state_q <= StTrack;
              tval_q  <= too_fast ? tval_inc : tval_dec;
            end
          end
        end
      endcase
      // Pass-through mode freezes the loop; leaving it resumes tracking directly.
      if (dco) begin
        lk_q   <= '0;
        locked <= 1'b0;
        if (state_q == StLocked) state_q <= StTrack;
      end
    end
  end

endmodule

// File: tb/tb_digital_fll_ctrl.sv
// Scoreboard bench for digital_fll_ctrl: osc periods are driven in whole
// clock cycles, a reference model predicts each measurement, and a monitor
// compares every meas_valid pulse (and the trim one cycle later).
module tb_digital_fll_ctrl;

  localparam int TW      = 26;
  localparam int TINIT   = 13;
  localparam int TOLV    = 0;
  localparam int CTHR    = 4;
  localparam int LOCKN   = 4;
  localparam int CNT_MAX = 127;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          dco = 1'b0;
  logic          osc = 1'b0;
  logic [4:0]    div = '0;
  logic [TW-1:0] ext_trim = '0;
  logic [TW-1:0] trim;
  logic          locked;
  logic [6:0]    meas;
  logic          meas_valid;

  digital_fll_ctrl dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .dco        (dco),
    .osc        (osc),
    .div        (div),
    .ext_trim   (ext_trim),
    .trim       (trim),
    .locked     (locked),
    .meas       (meas),
    .meas_valid (meas_valid)
  );

  always #5 clock = ~clock;

  typedef struct {
    int            meas;
    bit            locked;
    logic [TW-1:0] trim;
  } exp_t;

  exp_t sb[$];
  int   seq_p[$];
  bit   seq_d[$];

  int errors = 0;
  int checks = 0;

  // Reference model state
  int m_tval, m_lk;
  bit m_locked;

  logic [TW-1:0] trim_exp;
  bit            trim_pend = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [TW-1:0] th(input int n);
    logic [63:0] v;
    v = (64'd1 << n) - 64'd1;
    return v[TW-1:0];
  endfunction

  // Monitor: pop an expectation on each meas_valid, check trim a cycle later.
  always @(negedge clock) begin
    exp_t e;
    if (trim_pend) begin
      chk("trim_after_meas", 64'(trim), 64'(trim_exp));
      trim_pend = 0;
    end
    if (!reset && meas_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_meas_valid", 64'(1), 64'(0));
      end else begin
        e = sb.pop_front();
        chk("meas", 64'(meas), 64'(e.meas));
        chk("locked", 64'(locked), 64'(e.locked));
        trim_exp  = e.trim;
        trim_pend = 1;
      end
    end
  end

  task automatic push_meas(input int p, input bit d);
    exp_t x;
    int   m, e, a, st;
    m = (p > CNT_MAX) ? CNT_MAX : p;
    if (d || div == 0) begin
      m_lk     = 0;
      m_locked = 0;
    end else begin
      e = m - int'(div);
      a = (e < 0) ? -e : e;
      if (a <= TOLV) begin
        if (m_lk < LOCKN) m_lk++;
        if (m_lk >= LOCKN) m_locked = 1;
      end else begin
        m_lk     = 0;
        m_locked = 0;
        st       = (a >= CTHR) ? 2 : 1;
        if (e > 0) m_tval = (m_tval + st > TW) ? TW : m_tval + st;
        else       m_tval = (m_tval - st < 0) ? 0 : m_tval - st;
      end
    end
    x.meas   = m;
    x.locked = m_locked;
    x.trim   = d ? ext_trim : th(m_tval);
    sb.push_back(x);
  endtask

  // One osc period of p clocks starting with a rising edge; dco settles
  // after the previous measurement has been fully observed.
  task automatic drive_period(input int p, input bit d);
    int h;
    h = p / 2;
    for (int i = 0; i < p; i++) begin
      if (i == 0) osc = 1'b1;
      if (i == h) osc = 1'b0;
      if (i == 4) dco = d;
      @(negedge clock);
    end
  endtask

  task automatic add(input int p, input bit d);
    seq_p.push_back(p);
    seq_d.push_back(d);
  endtask

  task automatic run_seq();
    for (int k = 0; k <= seq_p.size(); k++) begin
      if (k > 0) push_meas(seq_p[k-1], seq_d[k-1]);
      if (k < seq_p.size()) begin
        drive_period(seq_p[k], seq_d[k]);
      end else begin
        osc = 1'b1;
        repeat (3) @(negedge clock);
        osc = 1'b0;
        repeat (6) @(negedge clock);
      end
    end
    chk("scoreboard_drained", 64'(sb.size()), 64'(0));
    seq_p.delete();
    seq_d.delete();
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset  = 1'b1;
    enable = 1'b0;
    dco    = 1'b0;
    osc    = 1'b0;
    repeat (2) @(negedge clock);
    reset    = 1'b0;
    m_tval   = TINIT;
    m_lk     = 0;
    m_locked = 0;
  endtask

  task automatic start_scn(input int d, input logic [TW-1:0] e);
    do_reset();
    div      = 5'(d);
    ext_trim = e;
    enable   = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  initial begin
    int d, p;
    bit dm;

    // Reset values
    do_reset();
    chk("reset_trim", 64'(trim), 64'(26'h0001FFF));
    chk("reset_locked", 64'(locked), 64'(0));
    chk("reset_meas", 64'(meas), 64'(0));
    chk("reset_meas_valid", 64'(meas_valid), 64'(0));

    // In band: lock on the 4th measurement
    start_scn(8, '0);
    for (int i = 0; i < 6; i++) add(8, 0);
    run_seq();

    // Fine step up
    start_scn(8, '0);
    for (int i = 0; i < 3; i++) add(10, 0);
    run_seq();

    // Coarse step up, saturating at full trim
    start_scn(8, '0);
    for (int i = 0; i < 10; i++) add(14, 0);
    run_seq();
    chk("trim_saturated", 64'(trim), 64'(26'h3FFFFFF));

    // Lock, one short period, relock
    start_scn(8, '0);
    for (int i = 0; i < 5; i++) add(8, 0);
    add(6, 0);
    for (int i = 0; i < 5; i++) add(8, 0);
    run_seq();

    // Pass-through mode, then resume tracking
    start_scn(8, 26'h155AAAA);
    dco = 1'b1;
    @(negedge clock);
    chk("dco_trim", 64'(trim), 64'(26'h155AAAA));
    chk("dco_locked", 64'(locked), 64'(0));
    for (int i = 0; i < 4; i++) add(12, 1);
    for (int i = 0; i < 5; i++) add(8, 0);
    run_seq();

    // div == 0 never adjusts or locks
    start_scn(0, '0);
    add(9, 0);
    add(5, 0);
    add(7, 0);
    run_seq();

    // Randomized scenarios
    for (int r = 0; r < 6; r++) begin
      d = $urandom_range(24, 4);
      start_scn(d, 26'($urandom));
      for (int i = 0; i < 10; i++) begin
        if ($urandom_range(1, 0) == 0) p = d;
        else p = d + $urandom_range(16, 0) - 8;
        if (p < 5) p = 5;
        dm = ($urandom_range(5, 0) == 0);
        add(p, dm);
      end
      run_seq();
    end

    // Static osc saturates the counter; then disable mid-measurement
    start_scn(8, '0);
    add(8, 0);
    add(150, 0);
    add(8, 0);
    run_seq();
    repeat (10) @(negedge clock);
    enable = 1'b0;
    repeat (2) @(negedge clock);
    chk("disable_trim", 64'(trim), 64'(th(TINIT)));
    chk("disable_locked", 64'(locked), 64'(0));
    repeat (10) @(negedge clock);
    chk("disable_no_meas", 64'(sb.size()), 64'(0));

    // Reset mid-track restores reset values on the next edge
    start_scn(8, '0);
    for (int i = 0; i < 3; i++) add(10, 0);
    run_seq();
    reset = 1'b1;
    @(negedge clock);
    chk("midreset_trim", 64'(trim), 64'(26'h0001FFF));
    chk("midreset_meas", 64'(meas), 64'(0));
    chk("midreset_locked", 64'(locked), 64'(0));
    chk("midreset_meas_valid", 64'(meas_valid), 64'(0));
    reset = 1'b0;
    repeat (3) @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
